// File: rtl/hw_status_led_pkg.sv
// hw_status_led_pkg: shared encodings for the multi-channel status LED block.
package hw_status_led_pkg;

  // Width of the per-channel millisecond counter.
  localparam int MS_W = 16;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_FLASH = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    F_ON  = 2'd0,
    F_OFF = 2'd1,
    F_GAP = 2'd2
  } fsm_e;

endpackage

// File: rtl/hw_status_led_ch.sv
// hw_status_led_ch: one LED channel engine (OFF / ON / BLINK / FLASH-CODE).
// Time advances only on iTick (1 ms). A write restarts the channel and wins
// over a coincident tick. oLevel is registered.
module hw_status_led_ch
  import hw_status_led_pkg::*;
#(
  parameter int    BLINK_MS     = 1000,
  parameter int    FLASH_ON_MS  = 150,
  parameter int    FLASH_OFF_MS = 250,
  parameter int    GAP_MS       = 1000,
  parameter mode_e RST_MODE     = MODE_OFF
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iTick,
  input  logic       iWr,
  input  mode_e      iMode,
  input  logic [3:0] iCode,
  output logic       oLevel
);

  localparam logic [MS_W-1:0] BLINK_LAST = MS_W'(BLINK_MS / 2 - 1);
  localparam logic [MS_W-1:0] ON_LAST    = MS_W'(FLASH_ON_MS - 1);
  localparam logic [MS_W-1:0] OFF_LAST   = MS_W'(FLASH_OFF_MS - 1);
  localparam logic [MS_W-1:0] GAP_LAST   = MS_W'(GAP_MS - 1);
  localparam logic            RST_LEVEL  = (RST_MODE == MODE_ON) || (RST_MODE == MODE_BLINK);

  mode_e           mode;
  logic [3:0]      code;
  logic [MS_W-1:0] msCnt;
  logic [3:0]      pulseCnt;
  fsm_e            fState;

  // Channel state machine; oLevel doubles as the BLINK phase bit.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      mode     <= RST_MODE;
      code     <= 4'd0;
      msCnt    <= '0;
      pulseCnt <= 4'd0;
      fState   <= F_ON;
      oLevel   <= RST_LEVEL;
    end else if (iWr) begin
      mode     <= iMode;
      code     <= iCode;
      msCnt    <= '0;
      pulseCnt <= 4'd0;
      fState   <= F_ON;
      oLevel   <= (iMode == MODE_ON) || (iMode == MODE_BLINK) ||
                  ((iMode == MODE_FLASH) && (iCode != 4'd0));
    end else begin
      case (mode)
        MODE_OFF: oLevel <= 1'b0;
        MODE_ON:  oLevel <= 1'b1;
        MODE_BLINK: begin
          if (iTick) begin
            if (msCnt == BLINK_LAST) begin
              msCnt  <= '0;
              oLevel <= ~oLevel;
            end else begin
              msCnt <= msCnt + 1'b1;
            end
          end
        end
        default: begin // MODE_FLASH; a zero code is treated as OFF
          if (code == 4'd0) begin
            oLevel <= 1'b0;
          end else if (iTick) begin
            case (fState)
              F_ON: begin
                if (msCnt == ON_LAST) begin
                  msCnt    <= '0;
                  pulseCnt <= pulseCnt + 1'b1;
                  fState   <= F_OFF;
                  oLevel   <= 1'b0;
                end else begin
                  msCnt <= msCnt + 1'b1;
                end
              end
              F_OFF: begin
                if (msCnt == OFF_LAST) begin
                  msCnt <= '0;
                  if (pulseCnt >= code) begin
                    fState <= F_GAP;
                    oLevel <= 1'b0;
                  end else begin
                    fState <= F_ON;
                    oLevel <= 1'b1;
                  end
                end else begin
                  msCnt <= msCnt + 1'b1;
                end
              end
              F_GAP: begin
                if (msCnt == GAP_LAST) begin
                  msCnt    <= '0;
                  pulseCnt <= 4'd0;
                  fState   <= F_ON;
                  oLevel   <= 1'b1;
                end else begin
                  msCnt <= msCnt + 1'b1;
                end
              end
              default: begin // unreachable encoding: restart the code
                msCnt    <= '0;
                pulseCnt <= 4'd0;
                fState   <= F_ON;
                oLevel   <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/hw_status_led.sv
// hw_status_led: NUM_CH programmable status LEDs driven from a shared 1 ms
// prescaler. Channel 0 comes out of reset blinking as the heartbeat.
// Optional macro HW_STATUS_LED_PWM_EN adds a global 4-bit brightness PWM
// (one extra output flop, so writes show up two cycles later).
module hw_status_led
  import hw_status_led_pkg::*;
#(
  parameter int  CLK_FREQ     = 125000000,
  parameter int  NUM_CH       = 4,
  parameter int  BLINK_MS     = 1000,
  parameter int  FLASH_ON_MS  = 150,
  parameter int  FLASH_OFF_MS = 250,
  parameter int  GAP_MS       = 1000,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iWr,
  input  logic [CH_W-1:0]   iCh,
  input  logic [1:0]        iMode,
  input  logic [3:0]        iCode,
  input  logic [3:0]        iBright,
  output logic [NUM_CH-1:0] oLED,
  output logic              oTick
);

  localparam logic [31:0] DIV_LAST = 32'(CLK_FREQ / 1000 - 1);

  logic [31:0]       preCnt;
  logic              tick;
  logic              wrOk;
  logic [NUM_CH-1:0] level;

  assign tick  = (preCnt == DIV_LAST);
  assign oTick = tick;
  // Out-of-range channel numbers are dropped here.
  assign wrOk  = iWr && (32'(iCh) < 32'(NUM_CH));

  // Millisecond prescaler: counts 0..DIV-1, ticking on the last count.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n)   preCnt <= '0;
    else if (tick) preCnt <= '0;
    else           preCnt <= preCnt + 32'd1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    hw_status_led_ch #(
      .BLINK_MS    (BLINK_MS),
      .FLASH_ON_MS (FLASH_ON_MS),
      .FLASH_OFF_MS(FLASH_OFF_MS),
      .GAP_MS      (GAP_MS),
      .RST_MODE    (mode_e'((i == 0) ? MODE_BLINK : MODE_OFF))
    ) u_ch (
      .iCLK  (iCLK),
      .iRST_n(iRST_n),
      .iTick (tick),
      .iWr   (wrOk && (iCh == CH_W'(i))),
      .iMode (mode_e'(iMode)),
      .iCode (iCode),
      .oLevel(level[i])
    );
  end

`ifdef HW_STATUS_LED_PWM_EN
  logic [3:0] pwmCnt;

  // Global brightness: gate every pattern level with a free-running PWM.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pwmCnt <= 4'd0;
      oLED   <= NUM_CH'(1);
    end else begin
      pwmCnt <= pwmCnt + 4'd1;
      oLED   <= level & {NUM_CH{pwmCnt < iBright}};
    end
  end
`else
  logic unusedBright;
  assign unusedBright = ^iBright;
  assign oLED         = level;
`endif

endmodule

// File: doc/hw_status_led.md
Name: hw_status_led

Overview:
- Multi-channel successor to the single heartbeat blinker: drives NUM_CH LED outputs, each independently programmable as OFF, ON, BLINK or FLASH-CODE (blink a count, then pause).
- Shared millisecond prescaler feeds per-channel timing engines.
- Sits beside the CPU peripherals. Firmware writes channel modes through a simple single-cycle write strobe.
- Channel 0 powers up as the heartbeat.

Parameters:
- CLK_FREQ, 125000000, iCLK frequency in Hz. CLK_FREQ/1000 must be ≥ 2.
- NUM_CH, 4, number of LED channels, 1..16.
- BLINK_MS, 1000, full BLINK period in ms. Must be even and ≥ 2.
- FLASH_ON_MS, 150, FLASH-CODE on time per pulse.
- FLASH_OFF_MS, 250, FLASH-CODE off time after each pulse.
- GAP_MS, 1000, FLASH-CODE pause after the last pulse.
- All *_MS values must be in 1..65535.

Ports:
- iCLK  in  1  system clock.
- iRST_n  in  1  asynchronous active-low reset.
- iWr  in  1  write strobe, one cycle per write.
- iCh  in  CH_W = max(1, clog2(NUM_CH))  target channel.
- iMode  in  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 FLASH.
- iCode  in  4  flash count, 1..15. Used only when iMode is FLASH.
- iBright  in  4  global brightness. Used only when HW_STATUS_LED_PWM_EN is defined.
- oLED  out  NUM_CH  LED drive, active high.
- oTick  out  1  1 ms tick, one cycle wide, for diagnostics.

Behaviour:
- Clock and reset: one clock, iCLK. Reset is asynchronous and active-low on iRST_n; all registers clear on it.
- Reset values:
  - ch0 mode = BLINK, phase cleared, oLED[0] = 1.
  - All other channels: mode = OFF, oLED = 0.
  - oTick = 0, prescaler = 0.
- Prescaler:
  - DIV = CLK_FREQ/1000 (integer division).
  - 32-bit counter runs 0..DIV-1.
  - oTick = 1 for exactly the cycle the counter equals DIV-1; the counter then wraps to 0.
  - Period is exactly DIV cycles.
- Per-channel state: mode (2 bits), code (4 bits), 16-bit ms counter, 4-bit pulse counter, FLASH FSM state. The ms counter advances only on tick cycles.
- OFF: output 0, counters held.
- ON: output 1, counters held.
- BLINK:
  - Output toggles when the ms counter reaches BLINK_MS/2 - 1 on a tick; the counter then returns to 0.
  - Result is a 50% duty cycle with period BLINK_MS.
- FLASH FSM:
  - States: F_ON → F_OFF → (F_ON, or F_GAP after the code-th pulse) → F_ON.
  - Output is 1 only in F_ON.
  - Each state lasts its *_MS value in ticks. The transition happens on the tick that completes the count.
  - The pulse counter increments on each F_ON→F_OFF transition and clears on F_GAP exit.
  - code = 0 behaves as OFF.
- Write:
  - iWr with iCh < NUM_CH latches iMode/iCode into that channel and restarts it on the next cycle: ms counter = 0, pulse counter = 0, FSM = F_ON.
  - Output after a write: ON/BLINK/FLASH → 1, OFF → 0.
  - The restart is independent of prescaler phase, so the first interval may be short by up to DIV-1 cycles.
- Writes with iCh ≥ NUM_CH are ignored.
- A write coinciding with a tick takes priority; that tick is not applied to the written channel. Other channels are unaffected.
- Rewriting the same mode still restarts the channel.
- Latency: a write is reflected on oLED one cycle after iWr; the output is registered.
- Asserting reset mid-pattern returns all channels to their reset values immediately, asynchronously.

Optional Feature:
- Macro: HW_STATUS_LED_PWM_EN.
- Defined:
  - A free-running 4-bit PWM counter advances every cycle.
  - Each oLED bit = pattern_level AND (pwm_cnt < iBright).
  - iBright = 0 forces dark; 15 gives 15/16 duty.
  - oLED remains registered, one extra flop stage, so write latency becomes 2 cycles.
- Undefined: oLED = pattern_level, iBright is ignored, write latency is 1 cycle.

Decomposition:
- Package hw_status_led_pkg holds:
  - mode encodings MODE_OFF/ON/BLINK/FLASH;
  - FSM state typedef (F_ON, F_OFF, F_GAP);
  - ms counter width constant (16).
- Sub-module hw_status_led_ch: one channel engine, instantiated NUM_CH times via generate.
- The prescaler stays in the top level.

Test Plan (all with CLK_FREQ=10000, so DIV=10; BLINK_MS=100, FLASH_ON_MS=3, FLASH_OFF_MS=5, GAP_MS=20; NUM_CH=4):
- Reset release:
  - oLED = 4'b0001.
  - oTick first pulses 10 cycles after reset release, then every 10 cycles.
  - oLED[0] toggles every 500 cycles.
- Write ch2 ON, then OFF: oLED[2] = 1 one cycle after the first iWr, and 0 one cycle after the second. Other bits are unchanged.
- Write ch1 FLASH code 3:
  - Three highs of 30 cycles each (±9 cycles on the first), separated by 50-cycle lows.
  - After the third pulse, a low of 50+200 cycles, then the pattern repeats.
- Write ch3 with iWr coincident with oTick: counter restarts from 0. Write to iCh=5 (width 2, so this wraps)… use NUM_CH=3 build with iCh=3 → no channel changes.
- Assert iRST_n low mid-FLASH on ch1: oLED goes to 4'b0001 asynchronously, with no clock edge required.
- With HW_STATUS_LED_PWM_EN defined, ch2 ON, iBright=4: oLED[2] is high 4 of every 16 cycles. With iBright=0, it stays constant 0.
